otter_pc_fetch: RTL and testbench
=================================

OTTER_PC_FETCH -- requirements
Module: otter_pc_fetch

Interface
REQ-001 Parameter: RESET_VEC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high; clears all state immediately.
REQ-004 pc_write  in  1  execute stage accepts current instruction; request to advance PC.
REQ-005 pc_sel  in  3  next-PC source: 0 pc+4, 1 jalr_addr, 2 branch_addr, 3 jal_addr, 4 mtvec, 5 mepc, 6-7 treated as 0.
REQ-006 jal_addr, branch_addr, jalr_addr  in  32 each  target addresses from branch address generator.
REQ-007 mtvec, mepc  in  32 each  trap vector and trap return address from CSR file.
REQ-008 imem_req  out  1  instruction memory read request.
REQ-009 imem_addr  out  32  instruction memory read address.
REQ-010 imem_ack  in  1  memory read data valid for current request.
REQ-011 pc  out  32  address of instruction currently held or being fetched.
REQ-012 pc_plus4  out  32  pc + 4, modulo 2^32 (combinational from pc).
REQ-013 fetch_valid  out  1  instruction at pc is available to execute.
REQ-014 misalign_trap  out  1  one-cycle pulse: control-transfer target misaligned.
REQ-015 misalign_addr  out  32  offending target; held until next trap.

Function
REQ-016 FSM states: HOLD, FETCH, READY.
REQ-017 HOLD: entered on reset; imem_req=0; fetch_valid=0; moves to FETCH on first clock edge after rst deasserts.
REQ-018 FETCH: imem_req=1, imem_addr=pc, both stable until imem_ack; on imem_ack go to READY.
REQ-019 READY: fetch_valid=1, imem_req=0; remain until pc_write=1.
REQ-020 pc_write honoured only in READY; ignored in HOLD and FETCH, including cycles with imem_ack=1.
REQ-021 On pc_write in READY: pc loads selected next-PC; state goes to FETCH next cycle; latency from pc_write to imem_req for new address: 1 cycle.
REQ-022 jalr target = jalr_addr with bit 0 forced to 0 before alignment check.
REQ-023 mtvec and mepc selections load value with bits [1:0] forced to 0; never trap.
REQ-024 Misalignment: selected target for sel 1/2/3 with bits [1:0] != 0 -> pc loads mtvec[31:2],2'b00 instead; misalign_trap=1 exactly one cycle (cycle after pc_write edge); misalign_addr = offending target.
REQ-025 sel 0 never traps; pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-026 pc changes only on reset or on an accepted pc_write.
REQ-027 Memory held off indefinitely (imem_ack=0) -> remain in FETCH, outputs stable; no timeout.

Reset
REQ-028 While rst=1: pc=RESET_VEC, state=HOLD, imem_req=0, fetch_valid=0, misalign_trap=0, misalign_addr=0.
REQ-029 rst asserted mid-FETCH or mid-READY: outstanding request abandoned immediately; a late imem_ack after reset release is ignored unless in FETCH.

Verification
REQ-030 Reset release, RESET_VEC=0: cycle 1 HOLD, cycle 2 imem_req=1, imem_addr=0; ack -> fetch_valid=1, pc=0.
REQ-031 READY at pc=0x100, pc_write=1, pc_sel=0 -> next cycle pc=0x104, imem_req=1, fetch_valid=0.
REQ-032 pc=0x200, pc_sel=1, jalr_addr=0x301 -> pc=0x300, no trap; jal_addr=0x302, pc_sel=3 -> pc=mtvec (0x80), misalign_trap one cycle, misalign_addr=0x302.
REQ-033 FETCH with imem_ack=0 for 5 cycles while pc_write pulsed -> pc, imem_addr unchanged; ack -> READY.
REQ-034 pc=0xFFFF_FFFC, pc_sel=0 -> pc=0x0000_0000; pc_sel=5, mepc=0x1003 -> pc=0x1000, no trap.
REQ-035 rst asserted during FETCH at pc=0x40 -> imem_req=0 within same cycle, pc=RESET_VEC.

Source files
------------

// File: rtl/otter_pc_fetch.sv
// OTTER program counter and instruction fetch sequencer.
// Holds the PC, issues one instruction-memory read per PC value, and
// presents the fetched instruction as valid until execute accepts it.
// Control-transfer targets that are not word aligned redirect to mtvec
// and raise a one-cycle misalignment trap.
module otter_pc_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] jal_addr,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jalr_addr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        misalign_trap,
  output logic [31:0] misalign_addr
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] target;
  logic        target_checked;
  logic        misaligned;
  logic [31:0] next_pc;
  logic        accept;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  // pc_write only counts while an instruction is actually on offer.
  assign accept    = (state == READY) && pc_write;

  // Select the next-PC candidate and flag whether it needs an alignment check.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    target         = pc_plus4;
    target_checked = 1'b0;
    case (pc_sel)
      3'd1: begin
        target         = {jalr_addr[31:1], 1'b0};
        target_checked = 1'b1;
      end
      3'd2: begin
        target         = branch_addr;
        target_checked = 1'b1;
      end
      3'd3: begin
        target         = jal_addr;
        target_checked = 1'b1;
      end
      3'd4:    target = {mtvec[31:2], 2'b00};
      3'd5:    target = {mepc[31:2], 2'b00};
      default: target = pc_plus4;
    endcase
  end

  assign misaligned = target_checked && (target[1:0] != 2'b00);
  assign next_pc    = misaligned ? {mtvec[31:2], 2'b00} : target;

  // Fetch sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) state <= HOLD;
    else     state <= state_next;
  end

  // Next-state and handshake outputs; request and valid drop as soon as
  // reset forces HOLD because they decode directly from the state.
  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    case (state)
      HOLD: state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = READY;
      end
      READY: begin
        fetch_valid = 1'b1;
        if (pc_write) state_next = FETCH;
      end
      default: state_next = HOLD;
    endcase
  end

  // PC advances only when execute accepts the current instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc <= RESET_VEC;
    else if (accept) pc <= next_pc;
  end

  // Trap pulse lasts one cycle; the offending address persists until the next trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_trap <= 1'b0;
      misalign_addr <= 32'h0000_0000;
    end else begin
      misalign_trap <= accept && misaligned;
      if (accept && misaligned) misalign_addr <= target;
    end
  end

endmodule

// File: tb/tb_otter_pc_fetch.sv
// Self-checking bench for otter_pc_fetch: directed control-flow vectors,
// a fetch-address / trap-address scoreboard, and inline state checks.
module tb_otter_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic [2:0]  pc_sel = 3'd0;
  logic [31:0] jal_addr = '0, branch_addr = '0, jalr_addr = '0;
  logic [31:0] mtvec = '0, mepc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] pc, pc_plus4, misalign_addr;
  logic        fetch_valid, misalign_trap;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_fetch_q[$];
  logic [31:0] exp_trap_q[$];
  logic        prev_req = 1'b0;

  otter_pc_fetch #(.RESET_VEC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .pc_sel(pc_sel),
    .jal_addr(jal_addr), .branch_addr(branch_addr), .jalr_addr(jalr_addr),
    .mtvec(mtvec), .mepc(mepc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .misalign_trap(misalign_trap),
    .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: each new fetch request and each trap pulse is matched
  // against the next expected entry queued by the stimulus.
  always @(negedge clk) begin
    if (imem_req && !prev_req) begin
      if (exp_fetch_q.size() == 0) check("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
      else check("fetch_addr", imem_addr, exp_fetch_q.pop_front());
    end
    if (misalign_trap) begin
      if (exp_trap_q.size() == 0) check("unexpected_trap", misalign_addr, 32'hDEAD_BEEF);
      else check("trap_addr", misalign_addr, exp_trap_q.pop_front());
    end
    prev_req = imem_req;
  end

  // Complete the outstanding fetch and confirm the instruction is presented.
  task automatic ack(input logic [31:0] exp_pc);
    int waited = 0;
    while (!imem_req && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    check("req_before_ack", {31'd0, imem_req}, 32'd1);
    @(posedge clk); #1 imem_ack = 1'b1;
    @(posedge clk); #1 imem_ack = 1'b0;
    @(negedge clk);
    check("ready_valid", {31'd0, fetch_valid}, 32'd1);
    check("ready_req",   {31'd0, imem_req},    32'd0);
    check("ready_pc",    pc, exp_pc);
  endtask

  // Issue one accepted pc_write from READY and check the cycle that follows.
  task automatic issue(input logic [2:0] sel, input logic [31:0] exp_pc,
                       input logic exp_trap, input logic [31:0] exp_maddr);
    exp_fetch_q.push_back(exp_pc);
    if (exp_trap) exp_trap_q.push_back(exp_maddr);
    @(posedge clk); #1 pc_sel = sel; pc_write = 1'b1;
    @(posedge clk); #1 pc_write = 1'b0;
    @(negedge clk);
    check("issue_pc",    pc, exp_pc);
    check("issue_req",   {31'd0, imem_req},      32'd1);
    check("issue_valid", {31'd0, fetch_valid},   32'd0);
    check("issue_trap",  {31'd0, misalign_trap}, {31'd0, exp_trap});
    if (exp_trap) begin
      @(negedge clk);
      check("trap_one_cycle", {31'd0, misalign_trap}, 32'd0);
      check("trap_addr_held", misalign_addr, exp_maddr);
    end
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    check("rst_pc",    pc, 32'h0);
    check("rst_req",   {31'd0, imem_req},      32'd0);
    check("rst_valid", {31'd0, fetch_valid},   32'd0);
    check("rst_trap",  {31'd0, misalign_trap}, 32'd0);
    check("rst_maddr", misalign_addr, 32'h0);

    // Release: one HOLD cycle, then fetch at RESET_VEC.
    exp_fetch_q.push_back(32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("fetch0_req",  {31'd0, imem_req}, 32'd1);
    check("fetch0_addr", imem_addr, 32'h0);
    ack(32'h0);

    // Sequential advance.
    branch_addr = 32'h100;
    issue(3'd2, 32'h100, 1'b0, 32'h0);  ack(32'h100);
    issue(3'd0, 32'h104, 1'b0, 32'h0);  ack(32'h104);

    // jalr bit 0 cleared, then misaligned jal redirects to mtvec.
    branch_addr = 32'h200;
    issue(3'd2, 32'h200, 1'b0, 32'h0);  ack(32'h200);
    jalr_addr = 32'h301;
    issue(3'd1, 32'h300, 1'b0, 32'h0);  ack(32'h300);
    mtvec = 32'h80; jal_addr = 32'h302;
    issue(3'd3, 32'h80, 1'b1, 32'h302); ack(32'h80);

    // Misaligned branch; mtvec low bits are masked on redirect.
    mtvec = 32'h83; branch_addr = 32'h106;
    issue(3'd2, 32'h80, 1'b1, 32'h106); ack(32'h80);

    // Memory held off while pc_write pulses; nothing may move.
    branch_addr = 32'h400;
    issue(3'd2, 32'h400, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 pc_write = 1'b1; pc_sel = 3'd0;
      @(negedge clk);
      check("holdoff_pc",   pc, 32'h400);
      check("holdoff_addr", imem_addr, 32'h400);
      check("holdoff_req",  {31'd0, imem_req}, 32'd1);
    end
    // Ack arrives with pc_write still high: pc_write is not honoured.
    @(posedge clk); #1 imem_ack = 1'b1;
    @(posedge clk); #1 imem_ack = 1'b0; pc_write = 1'b0;
    @(negedge clk);
    check("holdoff_valid", {31'd0, fetch_valid}, 32'd1);
    check("holdoff_pc_after", pc, 32'h400);

    // Wrap of pc+4, mepc/mtvec masking, reserved select.
    branch_addr = 32'hFFFF_FFFC;
    issue(3'd2, 32'hFFFF_FFFC, 1'b0, 32'h0); ack(32'hFFFF_FFFC);
    issue(3'd0, 32'h0000_0000, 1'b0, 32'h0); ack(32'h0);
    mepc = 32'h1003;
    issue(3'd5, 32'h1000, 1'b0, 32'h0); ack(32'h1000);
    issue(3'd4, 32'h80, 1'b0, 32'h0);   ack(32'h80);
    issue(3'd6, 32'h84, 1'b0, 32'h0);   ack(32'h84);

    // Reset mid-FETCH abandons the request immediately.
    branch_addr = 32'h40;
    issue(3'd2, 32'h40, 1'b0, 32'h0);
    @(posedge clk); #1 rst = 1'b1; imem_ack = 1'b1;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_pc",  pc, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    exp_fetch_q.push_back(32'h0);
    @(negedge clk);
    check("late_ack_hold_valid", {31'd0, fetch_valid}, 32'd0);
    check("late_ack_hold_req",   {31'd0, imem_req},    32'd0);
    @(posedge clk); #1 imem_ack = 1'b0;
    @(negedge clk);
    check("refetch_req",   {31'd0, imem_req},    32'd1);
    check("refetch_valid", {31'd0, fetch_valid}, 32'd0);
    ack(32'h0);

    repeat (2) @(negedge clk);
    check("fetch_q_empty", exp_fetch_q.size(), 32'd0);
    check("trap_q_empty",  exp_trap_q.size(),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
